// File: rtl/esdi_pkg.sv
// esdi_pkg: shared constants, responder states and opcode helper for the ESDI command responder.
package esdi_pkg;
    localparam int FRAME_BITS = 17;
    localparam logic [3:0] OP_REQ_STATUS = 4'h0;
    localparam logic [3:0] OP_REQ_CONFIG = 4'h1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_REL,
        S_RX_WAIT,
        S_DISPATCH,
        S_BUSY,
        S_RESP_WAIT,
        S_TX_WAIT,
        S_TX_REL
    } state_t;

    function automatic logic is_query(input logic [3:0] opcode);
        return opcode == OP_REQ_STATUS || opcode == OP_REQ_CONFIG;
    endfunction
endpackage

// File: rtl/esdi_input_sync.sv
// esdi_input_sync: STAGES-deep synchroniser for an asynchronous ESDI line, resetting to the idle-high level.
module esdi_input_sync #(
    parameter int STAGES = 3
) (
    input  logic aclk,
    input  logic areset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge aclk) begin
        if (areset) ff <= '1;
        else ff <= STAGES'({ff, d});
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/esdi_drive_cmd_responder.sv
// esdi_drive_cmd_responder: drive-side ESDI serial command receiver and status/config response transmitter.
// Optional ESDI_RESP_PARITY_INJECT_EN adds inject_parity_err to corrupt the transmitted response parity.
module esdi_drive_cmd_responder
    import esdi_pkg::*;
#(
    parameter int DATA_SETUP  = 6,
    parameter int SYNC_STAGES = 3,
    parameter int BIT_TIMEOUT = 1_000_000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        esdi_transfer_req,
    input  logic        esdi_command_data,
    output logic        esdi_transfer_ack,
    output logic        esdi_confstat_data,
    output logic        esdi_command_complete,
    output logic        esdi_attention,
    output logic        esdi_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_data,
    output logic        cmd_parity_err,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [15:0] resp_data,
    input  logic        cmd_done,
    input  logic        attention_set,
    input  logic        attention_clr,
`ifdef ESDI_RESP_PARITY_INJECT_EN
    input  logic        inject_parity_err,
`endif
    input  logic        drive_ready
);
    localparam int TW = $clog2(BIT_TIMEOUT + 1);
    localparam int SW = $clog2(DATA_SETUP + 2);

    logic req_s, data_s, inj, perr_acc, timed_out;
    state_t state, prev;
    logic [16:0] shift, tx;
    logic [4:0] bit_cnt;
    logic [SW-1:0] sc;
    logic [TW-1:0] tcnt;

    esdi_input_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .aclk(aclk), .areset(areset), .d(esdi_transfer_req), .q(req_s)
    );
    esdi_input_sync #(.STAGES(SYNC_STAGES)) u_data_sync (
        .aclk(aclk), .areset(areset), .d(esdi_command_data), .q(data_s)
    );

`ifdef ESDI_RESP_PARITY_INJECT_EN
    assign inj = inject_parity_err;
`else
    assign inj = 1'b0;
`endif

    assign cmd_data = shift[16:1];
    assign cmd_parity_err = (~^shift[16:1]) != shift[0];
    assign perr_acc = state == S_DISPATCH && cmd_ready && cmd_parity_err;
    // tcnt is only meaningful once prev has caught up with state
    assign timed_out = (state inside {S_RX_WAIT, S_RX_REL, S_TX_WAIT, S_TX_REL}) && state == prev
                       && tcnt == TW'(BIT_TIMEOUT - 1);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= S_IDLE;
            prev <= S_IDLE;
            shift <= '0;
            tx <= '0;
            bit_cnt <= '0;
            sc <= '0;
            tcnt <= '0;
            esdi_transfer_ack <= 1'b1;
            esdi_confstat_data <= 1'b1;
            esdi_command_complete <= 1'b0;
            cmd_valid <= 1'b0;
            resp_ready <= 1'b0;
        end else begin
            prev <= state;
            tcnt <= (state != prev) ? '0 : tcnt + TW'(1);
            if (timed_out) begin
                state <= S_IDLE;
                esdi_transfer_ack <= 1'b1;
                esdi_confstat_data <= 1'b1;
                esdi_command_complete <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_RX_WAIT: if (!req_s) begin
                        shift <= {shift[15:0], !data_s};
                        bit_cnt <= (state == S_IDLE) ? 5'd1 : bit_cnt + 5'd1;
                        esdi_transfer_ack <= 1'b0;
                        if (state == S_IDLE) esdi_command_complete <= 1'b1;
                        state <= S_RX_REL;
                    end
                    S_RX_REL: if (req_s) begin
                        esdi_transfer_ack <= 1'b1;
                        cmd_valid <= bit_cnt == 5'(FRAME_BITS);
                        state <= (bit_cnt == 5'(FRAME_BITS)) ? S_DISPATCH : S_RX_WAIT;
                    end
                    S_DISPATCH: if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (cmd_parity_err) begin
                            esdi_command_complete <= 1'b0;
                            state <= S_IDLE;
                        end else if (is_query(cmd_data[15:12])) begin
                            resp_ready <= 1'b1;
                            state <= S_RESP_WAIT;
                        end else state <= S_BUSY;
                    end
                    S_BUSY: if (cmd_done) begin
                        esdi_command_complete <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_RESP_WAIT: if (resp_valid) begin
                        resp_ready <= 1'b0;
                        tx <= {resp_data, ~^resp_data ^ inj};
                        bit_cnt <= '0;
                        sc <= '0;
                        esdi_confstat_data <= !resp_data[15];
                        state <= S_TX_WAIT;
                    end
                    S_TX_WAIT: begin
                        esdi_confstat_data <= !tx[16];
                        if (!req_s) begin
                            if (sc == SW'(DATA_SETUP)) begin
                                esdi_transfer_ack <= 1'b0;
                                state <= S_TX_REL;
                            end else sc <= sc + SW'(1);
                        end else sc <= '0;
                    end
                    S_TX_REL: if (req_s) begin
                        esdi_transfer_ack <= 1'b1;
                        tx <= {tx[15:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        sc <= '0;
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            esdi_confstat_data <= 1'b1;
                            esdi_command_complete <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            esdi_confstat_data <= !tx[15];
                            state <= S_TX_WAIT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            esdi_attention <= 1'b1;
            esdi_ready <= 1'b1;
        end else begin
            esdi_attention <= (attention_set || perr_acc) ? 1'b0 : attention_clr ? 1'b1 : esdi_attention;
            esdi_ready <= !drive_ready;
        end
    end
endmodule
